// File: rtl/datapath_if.sv
// Strobe, immediate and result bundle between a datapath controller and datapath_core.
// pc, ir and ir_immediate are reserved inputs that the core accepts and ignores.
interface datapath_if;
    logic        pco, iro, maro, mdro, ryo, r0o, r1o;
    logic        pci, iri, mari, mdri, ryi, r0i, r1i;
    logic [31:0] pc_immediate, mar_immediate, mdr_immediate;
    logic [31:0] pc, ir, ir_immediate;
    logic [31:0] bus_out, z_out;

    modport master (
        output pco, iro, maro, mdro, ryo, r0o, r1o,
        output pci, iri, mari, mdri, ryi, r0i, r1i,
        output pc_immediate, mar_immediate, mdr_immediate, pc, ir, ir_immediate,
        input  bus_out, z_out
    );

    modport slave (
        input  pco, iro, maro, mdro, ryo, r0o, r1o,
        input  pci, iri, mari, mdri, ryi, r0i, r1i,
        input  pc_immediate, mar_immediate, mdr_immediate, pc, ir, ir_immediate,
        output bus_out, z_out
    );
endinterface

// File: rtl/datapath_core.sv
// Single-bus CPU datapath: register file on a shared 32-bit bus, Y/bus ALU
// selected by IR[31:27], and a Z register that samples the ALU every cycle.
module datapath_core (
    input logic     clock,
    input logic     clear,
    datapath_if.slave dp
);
    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_SHR = 5'b00111;
    localparam logic [4:0] OP_ROR = 5'b01000;
    localparam logic [4:0] OP_ROL = 5'b01001;
    localparam logic [4:0] OP_SHL = 5'b01010;
    localparam logic [4:0] OP_NEG = 5'b01011;
    localparam logic [4:0] OP_NOT = 5'b01100;

    logic [31:0] pc_reg, ir_reg, mar_reg, mdr_reg, y_reg, r0_reg, r1_reg, z_reg;
    logic [31:0] bus;
    logic [31:0] alu_result;
    logic [4:0]  amount;
    logic [63:0] rot_right, rot_left;
    logic        unused_bits;

    // Fixed-priority bus mux; lower-priority drivers are masked, never merged.
    always_comb begin
        bus = 32'h0;
        if (dp.mdro)      bus = mdr_reg;
        else if (dp.maro) bus = mar_reg;
        else if (dp.pco)  bus = pc_reg;
        else if (dp.iro)  bus = ir_reg;
        else if (dp.ryo)  bus = y_reg;
        else if (dp.r0o)  bus = r0_reg;
        else if (dp.r1o)  bus = r1_reg;
    end

    // Rotates come from a doubled copy of Y so amount 0 and 31 need no special case.
    assign amount    = bus[4:0];
    assign rot_right = {y_reg, y_reg} >> amount;
    assign rot_left  = {y_reg, y_reg} << amount;

    always_comb begin
        alu_result = bus;
        case (ir_reg[31:27])
            OP_ADD:  alu_result = y_reg + bus;
            OP_SUB:  alu_result = y_reg - bus;
            OP_AND:  alu_result = y_reg & bus;
            OP_OR:   alu_result = y_reg | bus;
            OP_SHR:  alu_result = y_reg >> amount;
            OP_ROR:  alu_result = rot_right[31:0];
            OP_ROL:  alu_result = rot_left[63:32];
            OP_SHL:  alu_result = y_reg << amount;
            OP_NEG:  alu_result = 32'h0 - bus;
            OP_NOT:  alu_result = ~bus;
            default: alu_result = bus;
        endcase
    end

    // Loads see the pre-edge bus, so a register may drive and load in one cycle.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            pc_reg  <= 32'h0;
            ir_reg  <= 32'h0;
            mar_reg <= 32'h0;
            mdr_reg <= 32'h0;
            y_reg   <= 32'h0;
            r0_reg  <= 32'h0;
            r1_reg  <= 32'h0;
            z_reg   <= 32'h0;
        end else begin
            if (dp.pci)  pc_reg  <= dp.pc_immediate;
            if (dp.mari) mar_reg <= dp.mar_immediate;
            if (dp.mdri) mdr_reg <= dp.mdr_immediate;
            if (dp.iri)  ir_reg  <= bus;
            if (dp.ryi)  y_reg   <= bus;
            if (dp.r0i)  r0_reg  <= bus;
            if (dp.r1i)  r1_reg  <= bus;
            z_reg <= alu_result;
        end
    end

    assign dp.bus_out = bus;
    assign dp.z_out   = z_reg;

    assign unused_bits = ^{dp.pc, dp.ir, dp.ir_immediate, ir_reg[26:0],
                           rot_right[63:32], rot_left[31:0]};
endmodule

// File: tb/tb_datapath_core.sv
// Scoreboard bench for datapath_core: expected values are queued as stimulus is
// driven and popped when the bus or Z result is observed.
module tb_datapath_core;
    logic clock;
    logic clear;

    datapath_if dp ();

    datapath_core dut (
        .clock(clock),
        .clear(clear),
        .dp   (dp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } alu_vec_t;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] exp_v;
    string       nm_v;
    int          compared;
    int          mismatched;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        {dp.pco, dp.iro, dp.maro, dp.mdro, dp.ryo, dp.r0o, dp.r1o} = 7'h0;
        {dp.pci, dp.iri, dp.mari, dp.mdri, dp.ryi, dp.r0i, dp.r1i} = 7'h0;
    endtask

    // Mask order: pco, iro, maro, mdro, ryo, r0o, r1o.
    task automatic set_out_mask(input logic [6:0] m);
        {dp.pco, dp.iro, dp.maro, dp.mdro, dp.ryo, dp.r0o, dp.r1o} = m;
    endtask

    task automatic push(input logic [31:0] v, input string n);
        exp_q.push_back(v);
        name_q.push_back(n);
    endtask

    task automatic load_mdr(input logic [31:0] v);
        idle();
        dp.mdr_immediate = v;
        dp.mdri = 1'b1;
        cyc();
        idle();
    endtask

    task automatic set_y(input logic [31:0] v);
        load_mdr(v);
        dp.mdro = 1'b1;
        dp.ryi  = 1'b1;
        cyc();
        idle();
    endtask

    task automatic set_ir(input logic [4:0] op);
        load_mdr({op, 27'h0});
        dp.mdro = 1'b1;
        dp.iri  = 1'b1;
        cyc();
        idle();
    endtask

    task automatic test_reset();
        idle();
        dp.pc_immediate = 32'h0; dp.mar_immediate = 32'h0; dp.mdr_immediate = 32'h0;
        dp.pc = 32'hFFFF_FFFF; dp.ir = 32'hFFFF_FFFF; dp.ir_immediate = 32'hFFFF_FFFF;
        clear = 1'b1;
        cyc();
        cyc();
        push(32'h0, "reset_bus");
        push(32'h0, "reset_z");
        exp_v = exp_q.pop_front(); nm_v = name_q.pop_front(); compared++;
        if (dp.bus_out !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", nm_v, dp.bus_out, exp_v);
        end
        exp_v = exp_q.pop_front(); nm_v = name_q.pop_front(); compared++;
        if (dp.z_out !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", nm_v, dp.z_out, exp_v);
        end
        clear = 1'b0;
        push(32'h0, "post_reset_z");
        cyc();
        exp_v = exp_q.pop_front(); nm_v = name_q.pop_front(); compared++;
        if (dp.z_out !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", nm_v, dp.z_out, exp_v);
        end
    endtask

    task automatic test_load();
        logic [6:0] masks[5];
        load_mdr(32'h8000_0003);
        dp.mdro = 1'b1; dp.r0i = 1'b1;
        cyc(); idle();
        load_mdr(32'h0000_0002);
        dp.mdro = 1'b1; dp.r1i = 1'b1;
        cyc(); idle();
        dp.pc_immediate = 32'h1111_2222;  dp.pci  = 1'b1;
        dp.mar_immediate = 32'h3333_4444; dp.mari = 1'b1;
        cyc(); idle();
        repeat (3) cyc();
        masks = '{7'h02, 7'h01, 7'h40, 7'h10, 7'h02};
        push(32'h8000_0003, "load_r0");
        push(32'h0000_0002, "load_r1");
        push(32'h1111_2222, "load_pc");
        push(32'h3333_4444, "load_mar");
        push(32'h8000_0003, "hold_r0");
        for (int i = 0; i < 5; i++) begin
            set_out_mask(masks[i]);
            #1;
            exp_v = exp_q.pop_front(); nm_v = name_q.pop_front(); compared++;
            if (dp.bus_out !== exp_v) begin
                mismatched++;
                $display("[TB] FAIL %s: got %h expected %h", nm_v, dp.bus_out, exp_v);
            end
        end
        idle();
    endtask

    task automatic test_rol();
        load_mdr(32'h4800_0000);
        dp.mdro = 1'b1; dp.iri = 1'b1;
        cyc(); idle();
        dp.r0o = 1'b1; dp.ryi = 1'b1;
        cyc(); idle();
        dp.r1o = 1'b1;
        push(32'h0000_000E, "rol_r0_by_r1");
        cyc(); idle();
        exp_v = exp_q.pop_front(); nm_v = name_q.pop_front(); compared++;
        if (dp.z_out !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", nm_v, dp.z_out, exp_v);
        end
    endtask

    task automatic test_priority();
        logic [6:0]  masks[8];
        logic [31:0] expect_bus[8];
        masks      = '{7'h0A, 7'h74, 7'h61, 7'h24, 7'h05, 7'h03, 7'h7F, 7'h00};
        expect_bus = '{32'h4800_0000, 32'h3333_4444, 32'h1111_2222, 32'h4800_0000,
                       32'h8000_0003, 32'h8000_0003, 32'h4800_0000, 32'h0000_0000};
        for (int i = 0; i < 8; i++) begin
            set_out_mask(masks[i]);
            push(expect_bus[i], $sformatf("priority[%0d]", i));
            cyc();
            exp_v = exp_q.pop_front(); nm_v = name_q.pop_front(); compared++;
            if (dp.bus_out !== exp_v) begin
                mismatched++;
                $display("[TB] FAIL %s: got %h expected %h", nm_v, dp.bus_out, exp_v);
            end
        end
        idle();
    endtask

    task automatic test_same_cycle();
        dp.mdr_immediate = 32'hA5A5_A5A5;
        dp.mdri = 1'b1; dp.mdro = 1'b1; dp.r0i = 1'b1;
        cyc(); idle();
        push(32'h4800_0000, "same_cycle_r0_old_mdr");
        push(32'hA5A5_A5A5, "same_cycle_mdr_new");
        dp.r0o = 1'b1;
        #1;
        exp_v = exp_q.pop_front(); nm_v = name_q.pop_front(); compared++;
        if (dp.bus_out !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", nm_v, dp.bus_out, exp_v);
        end
        dp.mdro = 1'b1;
        #1;
        exp_v = exp_q.pop_front(); nm_v = name_q.pop_front(); compared++;
        if (dp.bus_out !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", nm_v, dp.bus_out, exp_v);
        end
        idle();
    endtask

    task automatic test_alu();
        alu_vec_t vecs[17];
        vecs = '{
            '{5'b01001, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678},
            '{5'b01000, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678},
            '{5'b01010, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678},
            '{5'b00111, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678},
            '{5'b01001, 32'h1234_5678, 32'h0000_0021, 32'h2468_ACF0},
            '{5'b00011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
            '{5'b00100, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF},
            '{5'b01011, 32'h0000_0005, 32'h0000_0001, 32'hFFFF_FFFF},
            '{5'b00101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000},
            '{5'b00110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0},
            '{5'b00111, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001},
            '{5'b01000, 32'h1234_5678, 32'h0000_0004, 32'h8123_4567},
            '{5'b01000, 32'h1234_5678, 32'h0000_001F, 32'h2468_ACF0},
            '{5'b01010, 32'h1234_5678, 32'h0000_0004, 32'h2345_6780},
            '{5'b01100, 32'h0000_0000, 32'h0F0F_0F0F, 32'hF0F0_F0F0},
            '{5'b00011, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030},
            '{5'b11111, 32'h0000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF}
        };
        for (int i = 0; i < 17; i++) begin
            set_y(vecs[i].a);
            set_ir(vecs[i].op);
            load_mdr(vecs[i].b);
            dp.mdro = 1'b1;
            push(vecs[i].e, $sformatf("alu[%0d] op=%b", i, vecs[i].op));
            cyc();
            idle();
            exp_v = exp_q.pop_front(); nm_v = name_q.pop_front(); compared++;
            if (dp.z_out !== exp_v) begin
                mismatched++;
                $display("[TB] FAIL %s: got %h expected %h", nm_v, dp.z_out, exp_v);
            end
        end
    endtask

    task automatic test_clear();
        logic [6:0] masks[7];
        // IR holds a pass-through opcode here, so Z mirrors R0.
        dp.r0o = 1'b1;
        push(32'h4800_0000, "pre_clear_z");
        cyc();
        exp_v = exp_q.pop_front(); nm_v = name_q.pop_front(); compared++;
        if (dp.z_out !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", nm_v, dp.z_out, exp_v);
        end
        #2;
        clear = 1'b1;
        push(32'h0, "clear_z_async");
        push(32'h0, "clear_r0_async");
        #1;
        exp_v = exp_q.pop_front(); nm_v = name_q.pop_front(); compared++;
        if (dp.z_out !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", nm_v, dp.z_out, exp_v);
        end
        exp_v = exp_q.pop_front(); nm_v = name_q.pop_front(); compared++;
        if (dp.bus_out !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", nm_v, dp.bus_out, exp_v);
        end
        idle();
        dp.mdr_immediate = 32'h0000_0077;
        dp.mdri = 1'b1; dp.pci = 1'b1; dp.mari = 1'b1;
        cyc();
        idle();
        masks = '{7'h40, 7'h20, 7'h10, 7'h08, 7'h04, 7'h02, 7'h01};
        for (int i = 0; i < 7; i++) begin
            set_out_mask(masks[i]);
            push(32'h0, $sformatf("cleared_reg[%0d]", i));
            cyc();
            exp_v = exp_q.pop_front(); nm_v = name_q.pop_front(); compared++;
            if (dp.bus_out !== exp_v) begin
                mismatched++;
                $display("[TB] FAIL %s: got %h expected %h", nm_v, dp.bus_out, exp_v);
            end
        end
        idle();
        clear = 1'b0;
        dp.mdri = 1'b1;
        cyc();
        idle();
        dp.mdro = 1'b1;
        push(32'h0000_0077, "load_after_clear");
        #1;
        exp_v = exp_q.pop_front(); nm_v = name_q.pop_front(); compared++;
        if (dp.bus_out !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", nm_v, dp.bus_out, exp_v);
        end
        idle();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        clear      = 1'b1;
        test_reset();
        test_load();
        test_rol();
        test_priority();
        test_same_cycle();
        test_alu();
        test_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
